// File: rtl/niu_sii_pkg.sv
// Shared types and header field positions for the NIU->SII request tracker.
package niu_sii_pkg;

    // Header field positions inside niu_sii_data
    localparam int HDR_TAG_MSB = 79;
    localparam int HDR_TAG_LSB = 64;
    localparam int HDR_PA_MSB  = 39;
    localparam int TAG_W       = HDR_TAG_MSB - HDR_TAG_LSB + 1;
    localparam int PA_W        = HDR_PA_MSB + 1;

    typedef enum logic [1:0] {
        EVT_RD   = 2'd0,
        EVT_WR   = 2'd1,
        EVT_WR16 = 2'd2
    } evt_kind_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } fsm_t;

    // One completed request as it sits in the event FIFO
    typedef struct packed {
        evt_kind_t          kind;
        logic               bypass;
        logic [TAG_W-1:0]   tag;
        logic [PA_W-1:0]    pa;
        logic               par_err;
    } evt_rec_t;

endpackage

// File: rtl/niu_sii_req_tracker_if.sv
// Request input bus and event/status output bus of the tracker.
interface niu_sii_req_tracker_if #(
    parameter int DATA_W    = 128,
    parameter int PAR_GRAIN = 16,
    parameter int CNT_W     = 16
);
    localparam int PAR_W = DATA_W / PAR_GRAIN;

    logic              enable;
    logic              niu_sii_hdr_vld;
    logic              niu_sii_reqbypass;
    logic              niu_sii_datareq;
    logic              niu_sii_datareq16;
    logic [DATA_W-1:0] niu_sii_data;
    logic [PAR_W-1:0]  niu_sii_parity;

    logic              evt_valid;
    logic              evt_ready;
    logic [1:0]        evt_kind;
    logic              evt_bypass;
    logic [15:0]       evt_tag;
    logic [39:0]       evt_pa;
    logic              evt_par_err;
    logic              err_overlap;
    logic              err_ovf;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    modport master (
        output enable, niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq,
               niu_sii_datareq16, niu_sii_data, niu_sii_parity, evt_ready,
        input  evt_valid, evt_kind, evt_bypass, evt_tag, evt_pa, evt_par_err,
               err_overlap, err_ovf, rd_cnt, wr_cnt
    );

    modport slave (
        input  enable, niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq,
               niu_sii_datareq16, niu_sii_data, niu_sii_parity, evt_ready,
        output evt_valid, evt_kind, evt_bypass, evt_tag, evt_pa, evt_par_err,
               err_overlap, err_ovf, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/niu_sii_evt_fifo.sv
// Synchronous event-record FIFO; extra pointer bit separates full from empty.
module niu_sii_evt_fifo
    import niu_sii_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  evt_rec_t rec_i,
    input  logic     pop_i,
    output evt_rec_t rec_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);

    evt_rec_t      mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop frees the slot the same cycle, so push while full succeeds with a pop
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rec_o     = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update; storage is cleared so outputs read zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= rec_i;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/niu_sii_req_tracker.sv
// Tracks NIU->SII inbound DMA requests: decodes headers, counts write beats,
// checks grain parity and header overlap, and queues one record per request.
module niu_sii_req_tracker
    import niu_sii_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int PAR_GRAIN = 16,
    parameter bit PAR_ODD   = 1'b1,
    parameter int WR_BEATS  = 4,
    parameter int EVT_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic iol2clk,
    input  logic rst_l,
    niu_sii_req_tracker_if.slave bus
);
    localparam int PAR_W = DATA_W / PAR_GRAIN;

    // Parity error for one grain: data XOR its parity bit must equal PAR_ODD
    function automatic logic grain_bad(input logic [PAR_GRAIN-1:0] g, input logic p);
        return ((^g) ^ p) != PAR_ODD;
    endfunction

    fsm_t             state_q;
    logic [3:0]       beat_cnt_q;
    evt_kind_t        kind_q;
    logic             bypass_q;
    logic [TAG_W-1:0] tag_q;
    logic [PA_W-1:0]  pa_q;
    logic             par_err_q;
    logic             err_overlap_q;
    logic             err_ovf_q;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic [PAR_W-1:0] grain_err_s;
    logic             par_bad_s;
    logic             hdr_take_s;
    logic             push_s;
    evt_rec_t         rec_s;
    evt_rec_t         fifo_rec_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;
    logic             unused_s;

    for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
        assign grain_err_s[gi] = grain_bad(bus.niu_sii_data[gi*PAR_GRAIN +: PAR_GRAIN],
                                           bus.niu_sii_parity[gi]);
    end

    assign par_bad_s  = |grain_err_s;
    assign hdr_take_s = (state_q == IDLE) && bus.enable && bus.niu_sii_hdr_vld;
    assign pop_s      = bus.evt_ready && !fifo_empty_s;
    assign unused_s   = ^{bus.niu_sii_data[DATA_W-1:HDR_TAG_MSB+1],
                          bus.niu_sii_data[HDR_TAG_LSB-1:HDR_PA_MSB+1]};

    // Build the record to push: a read at its header, a write at its last beat
    always_comb begin
        push_s = 1'b0;
        rec_s  = '0;
        if (state_q == PAYLOAD) begin
            if (beat_cnt_q == 4'd1) begin
                push_s        = 1'b1;
                rec_s.kind    = kind_q;
                rec_s.bypass  = bypass_q;
                rec_s.tag     = tag_q;
                rec_s.pa      = pa_q;
                rec_s.par_err = par_err_q | par_bad_s;
            end else begin
                push_s = 1'b0;
            end
        end else if (hdr_take_s && !bus.niu_sii_datareq16 && !bus.niu_sii_datareq) begin
            push_s        = 1'b1;
            rec_s.kind    = EVT_RD;
            rec_s.bypass  = bus.niu_sii_reqbypass;
            rec_s.tag     = bus.niu_sii_data[HDR_TAG_MSB:HDR_TAG_LSB];
            rec_s.pa      = bus.niu_sii_data[HDR_PA_MSB:0];
            rec_s.par_err = par_bad_s;
        end else begin
            push_s = 1'b0;
        end
    end

    // Header decode and payload beat tracking; overlap flag is a registered pulse
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= IDLE;
            beat_cnt_q    <= 4'd0;
            kind_q        <= EVT_RD;
            bypass_q      <= 1'b0;
            tag_q         <= '0;
            pa_q          <= '0;
            par_err_q     <= 1'b0;
            err_overlap_q <= 1'b0;
        end else begin
            err_overlap_q <= (state_q == PAYLOAD) && bus.niu_sii_hdr_vld;
            case (state_q)
                IDLE: begin
                    if (hdr_take_s && (bus.niu_sii_datareq16 || bus.niu_sii_datareq)) begin
                        state_q    <= PAYLOAD;
                        beat_cnt_q <= bus.niu_sii_datareq16 ? 4'd1 : 4'(WR_BEATS);
                        kind_q     <= bus.niu_sii_datareq16 ? EVT_WR16 : EVT_WR;
                        bypass_q   <= bus.niu_sii_reqbypass;
                        tag_q      <= bus.niu_sii_data[HDR_TAG_MSB:HDR_TAG_LSB];
                        pa_q       <= bus.niu_sii_data[HDR_PA_MSB:0];
                        par_err_q  <= par_bad_s;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PAYLOAD: begin
                    par_err_q <= par_err_q | par_bad_s;
                    if (beat_cnt_q == 4'd1) begin
                        state_q <= IDLE;
                    end else begin
                        beat_cnt_q <= beat_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating statistics: every push attempt counts, even one that is dropped
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (push_s && (rec_s.kind == EVT_RD)) begin
            rd_cnt_d = (&rd_cnt_q) ? rd_cnt_q : rd_cnt_q + 1'b1;
        end else if (push_s) begin
            wr_cnt_d = (&wr_cnt_q) ? wr_cnt_q : wr_cnt_q + 1'b1;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Counter and sticky overflow registers
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_ovf_q <= err_ovf_q | (push_s && fifo_full_s && !pop_s);
        end
    end

    niu_sii_evt_fifo #(.DEPTH(EVT_DEPTH)) u_fifo (
        .clk     (iol2clk),
        .rst_n   (rst_l),
        .push_i  (push_s),
        .rec_i   (rec_s),
        .pop_i   (pop_s),
        .rec_o   (fifo_rec_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign bus.evt_valid   = !fifo_empty_s;
    assign bus.evt_kind    = fifo_rec_s.kind;
    assign bus.evt_bypass  = fifo_rec_s.bypass;
    assign bus.evt_tag     = fifo_rec_s.tag;
    assign bus.evt_pa      = fifo_rec_s.pa;
    assign bus.evt_par_err = fifo_rec_s.par_err;
    assign bus.err_overlap = err_overlap_q;
    assign bus.err_ovf     = err_ovf_q;
    assign bus.rd_cnt      = rd_cnt_q;
    assign bus.wr_cnt      = wr_cnt_q;
endmodule
